// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch/control path: opcodes, IR field
// positions, fetch FSM states and next-PC selector codes.
package sisc_pkg;

    typedef enum logic [3:0] {
        OP_NOOP   = 4'd0,
        OP_LOD    = 4'd1,
        OP_STR    = 4'd2,
        OP_SWP    = 4'd3,
        OP_BRA    = 4'd4,
        OP_BRR    = 4'd5,
        OP_BNE    = 4'd6,
        OP_BNR    = 4'd7,
        OP_ALU_OP = 4'd8,
        OP_HLT    = 4'd15
    } opcode_e;

    localparam logic [3:0] AM_IMM = 4'd8;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_ABS,
        PC_REL
    } pc_sel_e;

endpackage

// File: rtl/sisc_pc_next.sv
// Combinational next-PC selector: hold, increment, absolute or relative
// target. All arithmetic wraps modulo 2^PC_W.
module sisc_pc_next
    import sisc_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  pc_sel_e         sel,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] imm,
    output logic [PC_W-1:0] next
);

    always_comb begin
        // NOTE: default assigned first so every path drives next; no latch.
        next = pc;
        unique case (sel)
            PC_INC:  next = pc + PC_W'(1);
            PC_ABS:  next = imm;
            PC_REL:  next = pc + imm;
            default: next = pc;
        endcase
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC instruction-fetch stage: PC/IR registers, variable-latency req/ack
// memory read with timeout abort, and branch PC updates (immediate or deferred).
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 32,
    parameter int              TIMEOUT  = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               fetch_start,
    input  logic               br_taken,
    input  logic               br_sel,
    input  logic [PC_W-1:0]    br_imm,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic               ir_valid,
    output logic               busy,
    output logic               err_timeout,
    output logic [PC_W-1:0]    pc
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    fetch_state_e    state, state_next;
    logic [7:0]      wait_cnt, cnt_inc;
    logic            pend_valid, pend_sel;
    logic [PC_W-1:0] pend_imm;
    pc_sel_e         pc_sel;
    logic [PC_W-1:0] pc_imm, pc_nxt;
    logic            ack_hit, abort, enter_idle;

    assign cnt_inc  = wait_cnt + 8'd1;
    assign busy     = (state != ST_IDLE);
    assign ir_valid = (state == ST_DONE);
    assign opcode   = ir[OPC_HI:OPC_LO];
    assign mm       = ir[MM_HI:MM_LO];

    always_ff @(posedge clk or negedge rst_f) begin
        // NOTE: non-blocking assignment for all sequential state.
        if (!rst_f) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pc_sel     = PC_HOLD;
        pc_imm     = br_imm;
        ack_hit    = 1'b0;
        abort      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (br_taken)    pc_sel = br_sel ? PC_REL : PC_ABS;
                if (fetch_start) state_next = ST_REQ;
            end
            ST_REQ:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (mem_ack) begin
                    ack_hit    = 1'b1;
                    pc_sel     = PC_INC;
                    state_next = ST_DONE;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // A branch resolved while busy lands on the edge back into IDLE; a
        // branch arriving on that very edge is the newest and wins.
        enter_idle = (state != ST_IDLE) && (state_next == ST_IDLE);
        if (enter_idle) begin
            if (br_taken) begin
                pc_sel = br_sel ? PC_REL : PC_ABS;
            end else if (pend_valid) begin
                pc_sel = pend_sel ? PC_REL : PC_ABS;
                pc_imm = pend_imm;
            end
        end
    end

    sisc_pc_next #(.PC_W(PC_W)) u_pc_next (
        .sel  (pc_sel),
        .pc   (pc),
        .imm  (pc_imm),
        .next (pc_nxt)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc          <= RESET_PC;
            ir          <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            err_timeout <= 1'b0;
            wait_cnt    <= '0;
            pend_valid  <= 1'b0;
            pend_sel    <= 1'b0;
            pend_imm    <= '0;
        end else begin
            pc <= pc_nxt;
            if (state == ST_REQ) begin
                mem_req  <= 1'b1;
                mem_addr <= pc;
                wait_cnt <= '0;
            end
            if (state == ST_WAIT && !mem_ack) wait_cnt <= cnt_inc;
            if (ack_hit) begin
                ir      <= mem_rdata;
                mem_req <= 1'b0;
            end
            if (abort) begin
                mem_req     <= 1'b0;
                err_timeout <= 1'b1;
            end
            if (enter_idle) begin
                pend_valid <= 1'b0;
            end else if (busy && br_taken) begin
                pend_valid <= 1'b1;
                pend_sel   <= br_sel;
                pend_imm   <= br_imm;
            end
        end
    end

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
Instruction-fetch stage of the SISC processor, directly upstream of the control FSM. Holds the program counter (PC) and instruction register (IR), and runs a req/ack read against instruction memory with variable latency. Decodes the IR fields (opcode, mm) that the control FSM consumes. Applies BRA/BRR/BNE/BNR PC updates when the control FSM resolves a branch.

Parameters:
PC_W, 16, PC and memory address width
INSTR_W, 32, instruction width
TIMEOUT, 15, max cycles to wait for mem_ack before abort (1..255)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge active
rst_f  in  1  asynchronous reset, active-low
fetch_start  in  1  one-cycle pulse from ctrl: fetch instruction at PC
br_taken  in  1  one-cycle pulse: branch resolved taken
br_sel  in  1  0 = absolute (PC <= br_imm), 1 = relative (PC <= PC + br_imm)
br_imm  in  PC_W  branch target or offset (two's complement when relative)
mem_ack  in  1  instruction memory has data valid this cycle
mem_rdata  in  INSTR_W  instruction word
mem_req  out  1  read request to instruction memory
mem_addr  out  PC_W  read address
ir  out  INSTR_W  instruction register
opcode  out  4  ir[31:28], combinational from ir
mm  out  4  ir[27:24], combinational from ir
ir_valid  out  1  one-cycle pulse: ir newly loaded
busy  out  1  high in any state other than IDLE
err_timeout  out  1  sticky: a fetch was aborted on timeout
pc  out  PC_W  current PC

Behaviour:
- Reset (rst_f low, asynchronous): state = IDLE, pc = RESET_PC, ir = 0 (NOOP), mem_req = 0, mem_addr = 0, ir_valid = 0, err_timeout = 0, wait counter = 0, branch-pending = 0. Reset asserted mid-fetch aborts the fetch immediately. A late mem_ack after release is ignored because the unit is in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if fetch_start, go to REQ.
- REQ: mem_req = 1, mem_addr = pc (registered outputs), counter cleared, go to WAIT.
- WAIT: mem_req held 1, mem_addr held stable.
  - If mem_ack: ir <= mem_rdata, pc <= pc + 1 (wraps mod 2^PC_W), mem_req <= 0, go to DONE.
  - Else counter increments. When counter == TIMEOUT: mem_req <= 0, err_timeout <= 1, ir and pc unchanged, go to IDLE. No ir_valid is produced.
- DONE: ir_valid = 1 for exactly this cycle, then go to IDLE.
- Latency: fetch_start at edge N; mem_req visible after edge N+1. With mem_ack in the first WAIT cycle, ir_valid is high one cycle after the ack edge. Minimum fetch_start to ir_valid is 3 cycles.
- mem_ack outside WAIT is ignored.
- fetch_start outside IDLE is ignored; no queueing.
- Branch handling:
  - br_taken in IDLE: pc updates at that edge. Absolute: pc <= br_imm. Relative: pc <= pc + br_imm, modulo 2^PC_W, where pc is already post-increment (next-instruction-relative).
  - br_taken and fetch_start in the same IDLE cycle: the branch updates pc at that edge, and REQ issues the new pc.
  - br_taken while busy: target latched into a one-entry pending register and applied on the cycle the FSM enters IDLE. It overrides the fetch's own pc + 1. A second br_taken while one is pending overwrites the pending one.
- err_timeout clears only on reset.
- opcode and mm are pure slices of ir; they hold their value between fetches so ctrl sees a stable instruction.

Decomposition:
- Shared package sisc_pkg:
  - opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15)
  - am_imm = 8
  - IR field positions (opcode 31:28, mm 27:24)
  - fetch state encoding
- One natural sub-module: sisc_pc_next, a combinational next-PC selector (hold / increment / absolute / relative). The fetch FSM stays in the top module.

Test Plan:
- Reset then fetch_start with mem_ack one cycle after mem_req, mem_rdata=0x81230004 -> mem_addr=0x0000, ir=0x81230004, opcode=8, mm=1, ir_valid pulses once, pc=0x0001.
- Memory wait of 5 cycles, TIMEOUT=15 -> mem_req held 5 cycles, mem_addr stable; ir loads on ack; err_timeout=0.
- No mem_ack ever -> mem_req drops after 15 WAIT cycles; err_timeout=1 and stays; pc and ir unchanged; busy=0; no ir_valid.
- pc=0x0010, br_taken with br_sel=1 and br_imm=0xFFFC in IDLE together with fetch_start -> pc=0x000C; mem_addr=0x000C.
- br_taken with br_sel=0 and br_imm=0x0040 during WAIT, then ack -> ir loads; pc=0x0040 (not pc+1) on return to IDLE.
- rst_f pulled low mid-WAIT, then ack after release -> outputs at reset values immediately; the late ack is ignored; pc=RESET_PC; ir=0.
